// File: rtl/input_bank_buffer_pkg.sv
// ---------------------------------------------------------------------------
// input_bank_buffer_pkg
// Shared definitions for the input bank buffer:
//   state_t     - stream controller state encoding (IDLE, STREAM, DONE)
//   FIFO_DEPTH  - number of beats the output skid FIFO can hold
//   lane_lsb()  - bit offset of a bank's lane inside the packed output beat
// ---------------------------------------------------------------------------
package input_bank_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

  // Bank 0 occupies the least significant lane of the output beat.
  function automatic int lane_lsb(input int bank, input int width);
    return bank * width;
  endfunction

endpackage

// File: rtl/input_bank_buffer_ram.sv
// ---------------------------------------------------------------------------
// input_bank_ram
// One storage bank: a simple dual-port memory with a synchronous write port
// and a synchronous read port (one cycle of read latency).
// Ports:
//   clk      - clock, rising edge
//   i_we     - write enable
//   i_waddr  - write word address
//   i_wdata  - write data
//   i_re     - read enable; the read register only updates when set
//   i_raddr  - read word address
//   o_rdata  - registered read data, valid the cycle after i_re
// Contents are intentionally not reset.
// ---------------------------------------------------------------------------
module input_bank_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // The read register holds its value when no read is issued, which keeps
  // the downstream head data stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/input_bank_buffer.sv
// ---------------------------------------------------------------------------
// input_bank_buffer
// Captures DMA loader writes into NUM_BANKS banks, then streams word i of
// every bank side by side to the systolic-array west feeder over valid/ready.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   wr_valid   - loader write strobe
//   wr_addr    - {bank, word} write address
//   wr_data    - write data
//   rd_start   - begin a stream (honoured only while idle)
//   rd_len     - words per bank to stream, 0..2^ADDR_WIDTH
//   out_valid  - output beat valid
//   out_ready  - consumer accepts the beat
//   out_data   - packed beat, bank 0 in the LSBs
//   out_last   - marks the final beat
//   busy       - controller is not idle
//   done       - single-cycle pulse when a stream completes
//   err_wr     - sticky flag: a write was dropped
// ---------------------------------------------------------------------------
module input_bank_buffer
  import input_bank_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int BRAM_INDEX     = 1,
  parameter int NUM_BANKS      = 2,
  parameter int DMA_DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  input  logic [BRAM_INDEX+ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DMA_DATA_WIDTH-1:0]          wr_data,
  input  logic                               rd_start,
  input  logic [ADDR_WIDTH:0]                rd_len,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_BANKS*DMA_DATA_WIDTH-1:0] out_data,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               err_wr
);

  localparam int OW = NUM_BANKS * DMA_DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [ADDR_WIDTH-1:0]   r_rdPtr;
  logic [ADDR_WIDTH:0]     r_len;
  logic [ADDR_WIDTH:0]     r_issued;
  logic                    r_inflight;
  logic                    r_inflightLast;
  logic [1:0]              r_fifoCount;
  logic [1:0]              w_fifoCountNext;
  logic [OW-1:0]           r_fifoData [FIFO_DEPTH];
  logic                    r_fifoLast [FIFO_DEPTH];
  logic                    r_errWr;

  logic [BRAM_INDEX-1:0]   w_bank;
  logic [ADDR_WIDTH-1:0]   w_word;
  logic                    w_bankOk;
  logic                    w_wrAccept;
  logic                    w_wrDrop;
  logic [2:0]              w_occupancy;
  logic                    w_issue;
  logic [OW-1:0]           w_ramData;
  logic                    w_fifoEmpty;
  logic                    w_outValid;
  logic [OW-1:0]           w_headData;
  logic                    w_headLast;
  logic                    w_pop;
  logic                    w_popFifo;
  logic                    w_push;
  logic                    w_pushIdx;
  logic                    w_start;
  logic                    w_done;

  // Write path: writes land only while idle and only into existing banks.
  assign w_bank     = wr_addr[BRAM_INDEX+ADDR_WIDTH-1 -: BRAM_INDEX];
  assign w_word     = wr_addr[ADDR_WIDTH-1:0];
  assign w_bankOk   = ({1'b0, w_bank} < (BRAM_INDEX+1)'(NUM_BANKS));
  assign w_wrAccept = wr_valid && (r_state == ST_IDLE) && w_bankOk;
  assign w_wrDrop   = wr_valid && !((r_state == ST_IDLE) && w_bankOk);

  // A read is only issued when the FIFO is guaranteed room for its return,
  // counting the read already in flight.
  assign w_occupancy = {1'b0, r_fifoCount} + {2'b00, r_inflight};
  assign w_issue     = (r_state == ST_STREAM) && (r_issued < r_len) &&
                       (w_occupancy < 3'(FIFO_DEPTH));

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam logic [BRAM_INDEX-1:0] BANK_ID = BRAM_INDEX'(b);
      logic w_we;
      assign w_we = w_wrAccept && (w_bank == BANK_ID);
      input_bank_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DMA_DATA_WIDTH)
      ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_word),
        .i_wdata (wr_data),
        .i_re    (w_issue),
        .i_raddr (r_rdPtr),
        .o_rdata (w_ramData[lane_lsb(b, DMA_DATA_WIDTH) +: DMA_DATA_WIDTH])
      );
    end
  endgenerate

  // Returning read data is presented straight to the consumer when the FIFO
  // is empty, so word 0 appears the cycle after its read is issued. Data
  // only enters FIFO storage if it is not taken in that same cycle.
  assign w_fifoEmpty = (r_fifoCount == 2'd0);
  assign w_outValid  = !w_fifoEmpty || r_inflight;
  assign w_headData  = w_fifoEmpty ? w_ramData : r_fifoData[0];
  assign w_headLast  = w_fifoEmpty ? r_inflightLast : r_fifoLast[0];
  assign w_pop       = w_outValid && out_ready;
  assign w_popFifo   = w_pop && !w_fifoEmpty;
  assign w_push      = r_inflight && !(w_fifoEmpty && w_pop);
  // Entry 0 is always the head; a push lands in the first free slot after
  // any same-cycle shift caused by a pop.
  assign w_pushIdx   = w_popFifo ? (r_fifoCount == 2'd2) : (r_fifoCount == 2'd1);

  assign w_start = (r_state == ST_IDLE) && rd_start;

  always_comb begin
    w_fifoCountNext = r_fifoCount;
    case ({w_push, w_popFifo})
      2'b10:   w_fifoCountNext = r_fifoCount + 2'd1;
      2'b01:   w_fifoCountNext = r_fifoCount - 2'd1;
      default: w_fifoCountNext = r_fifoCount;
    endcase
  end

  // Next-state and status outputs.
  always_comb begin
    w_nextState = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_start) begin
          w_nextState = (rd_len == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_pop && w_headLast) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Controller state, issue bookkeeping, FIFO occupancy and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_rdPtr        <= '0;
      r_len          <= '0;
      r_issued       <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
      r_fifoCount    <= 2'd0;
      r_errWr        <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_fifoCount <= w_fifoCountNext;
      r_inflight  <= w_issue;
      if (w_start && (rd_len != '0)) begin
        r_len    <= rd_len;
        r_rdPtr  <= '0;
        r_issued <= '0;
      end else if (w_issue) begin
        r_rdPtr        <= r_rdPtr + PTR_ONE;
        r_issued       <= r_issued + LEN_ONE;
        r_inflightLast <= (r_issued == (r_len - LEN_ONE));
      end
      if (w_wrDrop) begin
        r_errWr <= 1'b1;
      end
    end
  end

  // FIFO payload needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_popFifo) begin
      r_fifoData[0] <= r_fifoData[1];
      r_fifoLast[0] <= r_fifoLast[1];
    end
    if (w_push) begin
      r_fifoData[w_pushIdx] <= w_ramData;
      r_fifoLast[w_pushIdx] <= r_inflightLast;
    end
  end

  assign out_valid = w_outValid;
  assign out_data  = w_outValid ? w_headData : '0;
  assign out_last  = w_outValid && w_headLast;
  assign busy      = (r_state != ST_IDLE);
  assign done      = w_done;
  assign err_wr    = r_errWr;

endmodule

// File: tb/tb_input_bank_buffer.sv
// ---------------------------------------------------------------------------
// tb_input_bank_buffer
// Self-checking bench for input_bank_buffer: a stream-scenario table, random
// fills and back-pressure against a memory model, and a mid-stream reset.
// ---------------------------------------------------------------------------
module tb_input_bank_buffer;

  localparam int AW    = 5;
  localparam int BI    = 1;
  localparam int NB    = 2;
  localparam int DW    = 32;
  localparam int OW    = NB * DW;
  localparam int DEPTH = 2**AW;
  localparam int DC    = -2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_valid;
  logic [BI+AW-1:0] wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rd_start;
  logic [AW:0]     rd_len;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            err_wr;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [NB][DEPTH];
  logic          expErr;

  typedef struct {
    int len;
    int mode;
    int flags;
    int expFirst;
    int expLast;
    int expDone;
  } vec_t;

  vec_t vecs [7];

  input_bank_buffer #(
    .ADDR_WIDTH     (AW),
    .BRAM_INDEX     (BI),
    .NUM_BANKS      (NB),
    .DMA_DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_start  (rd_start),
    .rd_len    (rd_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err_wr    (err_wr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [OW-1:0] actual,
                             input logic [OW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [BI+AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic rs,
                               input logic [AW:0] rl, input logic rdy);
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    rd_start  = rs;
    rd_len    = rl;
    out_ready = rdy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input int bank, input int word, input logic [DW-1:0] data);
    applyStimulus(1'b1, {BI'(bank), AW'(word)}, data, 1'b0, '0, 1'b1);
    nextCycle();
    model[bank][word] = data;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [OW-1:0] expBeat(input int i);
    logic [OW-1:0] r;
    r = '0;
    for (int bk = 0; bk < NB; bk++) r[bk*DW +: DW] = model[bk][i];
    return r;
  endfunction

  function automatic logic readyAt(input int mode, input int c);
    logic [6:0] pat;
    pat = 7'b1101001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[c % 7];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // flags: bit0 pulse rd_start mid-stream, bit1 write during stream,
  //        bit2 write bank0 word0 in the same cycle as rd_start
  task automatic runStream(input int len, input int mode, input int flags,
                           output int firstCycle, output int lastCycle,
                           output int doneCycle);
    int            beat;
    bit            prevStall;
    logic [OW-1:0] prevData;
    logic          prevLast;
    bit            seenDone;
    bit            finished;
    logic          rdy;
    logic          wv;
    logic [DW-1:0] nv;
    int            budget;
    beat = 0; prevStall = 0; prevData = '0; prevLast = 0;
    seenDone = 0; finished = 0; budget = 4 * len + 40;
    firstCycle = -1; lastCycle = -1; doneCycle = -1;
    rdy = readyAt(mode, 0);
    if ((flags & 4) != 0) begin
      nv = $urandom;
      applyStimulus(1'b1, {BI'(0), AW'(0)}, nv, 1'b1, (AW+1)'(len), rdy);
      model[0][0] = nv;
    end else begin
      applyStimulus(1'b0, '0, '0, 1'b1, (AW+1)'(len), rdy);
    end
    @(negedge clk);
    checkOutput("idle_busy", OW'(busy), OW'(0));
    nextCycle();
    for (int c = 1; c <= budget && !finished; c++) begin
      rdy = readyAt(mode, c);
      wv  = ((flags & 2) != 0) && (c == 3);
      applyStimulus(wv, {BI'(1), AW'(0)}, 32'hFF, ((flags & 1) != 0) && (c == 5),
                    (AW+1)'(1), rdy);
      if (wv) expErr = 1'b1;
      @(negedge clk);
      if (seenDone) begin
        checkOutput("done_single", OW'(done), OW'(0));
        checkOutput("busy_after_done", OW'(busy), OW'(0));
        finished = 1;
      end else begin
        if (prevStall) begin
          checkOutput("stall_valid", OW'(out_valid), OW'(1));
          checkOutput("stall_data", out_data, prevData);
          checkOutput("stall_last", OW'(out_last), OW'(prevLast));
        end
        if (out_valid) begin
          if (firstCycle < 0) firstCycle = c;
          if (beat >= len) begin
            checkOutput("extra_beat", OW'(out_valid), OW'(0));
          end else if (rdy) begin
            checkOutput($sformatf("beat%0d_data", beat), out_data, expBeat(beat));
            checkOutput($sformatf("beat%0d_last", beat), OW'(out_last),
                        OW'(beat == len - 1));
            if (out_last) lastCycle = c;
            beat++;
          end
        end
        prevStall = out_valid && !rdy;
        prevData  = out_data;
        prevLast  = out_last;
        if (done) begin
          doneCycle = c;
          seenDone  = 1;
          checkOutput("beat_count", OW'(beat), OW'(len));
        end
      end
      nextCycle();
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL stream_timeout: got no completion, required done within %0d cycles", budget);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, OW'(out_valid), OW'(0));
    checkOutput({tag, "_last"},  OW'(out_last),  OW'(0));
    checkOutput({tag, "_busy"},  OW'(busy),      OW'(0));
    checkOutput({tag, "_done"},  OW'(done),      OW'(0));
    checkOutput({tag, "_err"},   OW'(err_wr),    OW'(0));
    checkOutput({tag, "_data"},  out_data,       OW'(0));
  endtask

  initial begin
    int fc, lc, dc, n, ln;
    rst = 1'b0;
    expErr = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    #12;
    checkAllZero("reset");
    nextCycle();
    rst = 1'b1;
    nextCycle();

    for (int w = 0; w < DEPTH; w++) begin
      writeWord(0, w, DW'(32'h10 + w));
      writeWord(1, w, DW'(32'h20 + w));
    end

    vecs[0] = '{4,  0, 0, 2,  5,  6};
    vecs[1] = '{4,  1, 0, 2,  DC, DC};
    vecs[2] = '{0,  0, 0, -1, -1, 1};
    vecs[3] = '{4,  0, 2, 2,  5,  6};
    vecs[4] = '{4,  0, 0, 2,  5,  6};
    vecs[5] = '{32, 0, 1, 2,  33, 34};
    vecs[6] = '{3,  0, 4, 2,  4,  5};

    for (int v = 0; v < 7; v++) begin
      runStream(vecs[v].len, vecs[v].mode, vecs[v].flags, fc, lc, dc);
      if (vecs[v].expFirst != DC) checkOutput($sformatf("v%0d_first", v), OW'(fc), OW'(vecs[v].expFirst));
      if (vecs[v].expLast  != DC) checkOutput($sformatf("v%0d_last", v),  OW'(lc), OW'(vecs[v].expLast));
      if (vecs[v].expDone  != DC) checkOutput($sformatf("v%0d_done", v),  OW'(dc), OW'(vecs[v].expDone));
      checkOutput($sformatf("v%0d_err", v), OW'(err_wr), OW'(expErr));
    end

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        writeWord($urandom_range(0, NB - 1), $urandom_range(0, DEPTH - 1), DW'($urandom));
      end
      ln = $urandom_range(1, DEPTH);
      runStream(ln, 2, 0, fc, lc, dc);
      checkOutput($sformatf("rand%0d_first", it), OW'(fc), OW'(2));
    end

    // Mid-stream reset while beat 2 of a 4-beat stream is on the output.
    applyStimulus(1'b0, '0, '0, 1'b1, (AW+1)'(4), 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("pre_reset_valid", OW'(out_valid), OW'(1));
    checkOutput("pre_reset_data", out_data, expBeat(2));
    #1;
    rst = 1'b0;
    expErr = 1'b0;
    #1;
    checkAllZero("midreset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("midreset_no_done", OW'(done), OW'(0));
    end
    nextCycle();
    rst = 1'b1;
    nextCycle();
    runStream(1, 0, 0, fc, lc, dc);
    checkOutput("post_reset_first", OW'(fc), OW'(2));
    checkOutput("post_reset_done", OW'(dc), OW'(3));
    checkOutput("post_reset_err", OW'(err_wr), OW'(expErr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
